// File: rtl/fft_pkg.sv
// Shared types and limits for the FFT streaming front end.
// A beat carries one complex sample plus its frame tags and transform settings.
package fft_pkg;

   localparam int DATA_W  = 32;
   localparam int PTS_W   = 19;
   localparam int MIN_PTS = 64;
   localparam int MAX_PTS = 262144;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic              sop;
      logic              eop;
      logic [PTS_W-1:0]  pts;
      logic              inverse;
   } beat_t;

   // Power of two within [MIN_PTS, MAX_PTS]; zero fails the range test.
   function automatic logic is_legal_pts(input logic [PTS_W-1:0] pts);
      return ((pts & (pts - 1'b1)) == '0) &&
             (pts >= PTS_W'(MIN_PTS)) && (pts <= PTS_W'(MAX_PTS));
   endfunction

endpackage

// File: rtl/fft_st_skid.sv
// Two-entry registered skid buffer, FIFO order; the head entry drives the outputs.
// occ_next exposes next-cycle occupancy so a caller can register its own ready.
module fft_st_skid
   import fft_pkg::*;
#(
   parameter type T = beat_t
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  T           push_data,
   input  logic       pop_ready,
   output logic       out_valid,
   output T           out_data,
   output logic [1:0] occ_next
);

   logic [1:0] cnt_q;
   T           head_q;
   T           tail_q;
   logic       pop;
   logic       push_ok;

   assign pop     = (cnt_q != 2'd0) && pop_ready;
   assign push_ok = push && ((cnt_q != 2'd2) || pop);

   always_comb begin
      occ_next = cnt_q;
      unique case ({push_ok, pop})
         2'b10:   occ_next = cnt_q + 2'd1;
         2'b01:   occ_next = cnt_q - 2'd1;
         default: occ_next = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q <= occ_next;
         // Head keeps its last contents when drained so the outputs hold.
         if (push_ok && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
            head_q <= push_data;
         else if (pop && (cnt_q == 2'd2))
            head_q <= tail_q;
         if (push_ok && (((cnt_q == 2'd1) && !pop) || (cnt_q == 2'd2)))
            tail_q <= push_data;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q;

endmodule

// File: rtl/fft_frame_source.sv
// Frames an unframed complex-sample stream into sop/eop-delimited FFT input frames,
// with per-frame points/direction carried on every beat through a registered skid.
module fft_frame_source
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [PTS_W-1:0]  cfg_pts,
   input  logic              cfg_inverse,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_imag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [1:0]        out_error,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_imag,
   output logic [PTS_W-1:0]  out_fftpts,
   output logic              out_inverse,
   output logic              busy,
   output logic              cfg_err,
   output logic [31:0]       frame_count
);

   state_t            state_q, state_d;
   logic [PTS_W-1:0]  pts_q;
   logic [PTS_W-1:0]  cnt_q;
   logic              inv_q;
   logic              cfg_rdy_q, cfg_rdy_d;
   logic              in_rdy_q, in_rdy_d;
   logic              cfg_err_q;
   logic [31:0]       frame_cnt_q;
   logic              cfg_fire, cfg_legal, in_fire;
   logic [1:0]        occ_next;
   beat_t             beat, head;

   assign cfg_fire  = cfg_valid && cfg_rdy_q;
   assign cfg_legal = is_legal_pts(cfg_pts);
   assign in_fire   = in_valid && in_rdy_q;

   always_comb begin
      beat         = '0;
      beat.re      = in_real;
      beat.im      = in_imag;
      beat.sop     = (cnt_q == '0);
      beat.eop     = (cnt_q == (pts_q - 1'b1));
      beat.pts     = pts_q;
      beat.inverse = inv_q;
   end

   // Both readies are registered from next-state values, cutting every ready path.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (cfg_fire && cfg_legal) state_d = STREAM;
         STREAM: if (in_fire && beat.eop)   state_d = IDLE;
      endcase
      cfg_rdy_d = (state_d == IDLE);
      in_rdy_d  = (state_d == STREAM) && (occ_next != 2'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cfg_rdy_q   <= 1'b0;
         in_rdy_q    <= 1'b0;
         pts_q       <= '0;
         inv_q       <= 1'b0;
         cnt_q       <= '0;
         cfg_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cfg_rdy_q <= cfg_rdy_d;
         in_rdy_q  <= in_rdy_d;
         if (cfg_fire && cfg_legal) begin
            pts_q <= cfg_pts;
            inv_q <= cfg_inverse;
            cnt_q <= '0;
         end else if (in_fire) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (cfg_fire && !cfg_legal)
            cfg_err_q <= 1'b1;
         if (out_valid && out_ready && head.eop)
            frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

   fft_st_skid #(.T(beat_t)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (in_fire),
      .push_data (beat),
      .pop_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (head),
      .occ_next  (occ_next)
   );

   assign cfg_ready   = cfg_rdy_q;
   assign in_ready    = in_rdy_q;
   assign out_sop     = head.sop;
   assign out_eop     = head.eop;
   assign out_error   = 2'b00;
   assign out_real    = head.re;
   assign out_imag    = head.im;
   assign out_fftpts  = head.pts;
   assign out_inverse = head.inverse;
   assign busy        = (state_q == STREAM) || out_valid;
   assign cfg_err     = cfg_err_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: doc/fft_frame_source.md
Name: fft_frame_source

Overview:
- Upstream framing stage feeding the FFT core's Avalon-ST sink.
- Takes an unframed complex-sample stream plus a per-frame configuration handshake (points, direction).
- Emits sop/eop-delimited frames with fftpts/inverse held stable for every beat of the frame.
- Holds a registered two-entry skid output, so ready paths are cut in both directions.

Parameters:
DATA_W, 32, width of each real/imag component
PTS_W, 19, width of points field (matches FFT fftpts_in)
MIN_PTS, 64, smallest legal frame length
MAX_PTS, 262144, largest legal frame length (2^18)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  frame configuration offered
cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid
cfg_pts  in  PTS_W  frame length in samples
cfg_inverse  in  1  1 = inverse transform
in_valid  in  1  sample offered
in_ready  out  1  sample accepted when high with in_valid
in_real  in  DATA_W  sample real part
in_imag  in  DATA_W  sample imaginary part
out_valid  out  1  to FFT sink_valid
out_ready  in  1  from FFT sink_ready
out_sop  out  1  to sink_sop
out_eop  out  1  to sink_eop
out_error  out  2  to sink_error; always 2'b00
out_real  out  DATA_W  to sink_real
out_imag  out  DATA_W  to sink_imag
out_fftpts  out  PTS_W  to fftpts_in
out_inverse  out  1  to inverse
busy  out  1  frame in progress or skid non-empty
cfg_err  out  1  sticky: illegal cfg_pts seen
frame_count  out  32  completed frames (eop beats accepted downstream), wraps

Behaviour:
- Reset: all outputs 0, state IDLE, skid empty, counters 0.
- Reset mid-frame: the frame is dropped with no eop generated. The FFT core is reset from the same source.
- FSM states: IDLE, STREAM.
- IDLE: cfg_ready=1, in_ready=0.
  - On cfg_valid, cfg_pts is legal if it is a power of two and MIN_PTS<=cfg_pts<=MAX_PTS.
  - Legal: latch pts/inverse, clear sample counter, go to STREAM.
  - Illegal: consume the cfg, set cfg_err (cleared only by reset), stay in IDLE.
- STREAM: cfg_ready=0; in_ready = skid has a free entry.
  - Beat tags are computed when the beat is accepted:
    - sop = (cnt==0)
    - eop = (cnt==pts-1)
  - Each beat is stored in the skid together with its tags and the latched pts/inverse.
  - cnt increments per accepted beat.
  - Accepting the eop beat returns the FSM to IDLE in the next cycle. The skid may still be draining; a new cfg is accepted then, giving back-to-back frames.
- Skid: two entries, FIFO order.
  - out_* reflect the head entry and are driven from registers.
  - out_valid = head occupied.
  - Head pops when out_valid&&out_ready; a push and a pop can happen in the same cycle.
  - Latency: a beat accepted in cycle N is on out_* in cycle N+1 if the skid was empty.
  - Throughput: 1 beat/cycle under continuous out_ready.
- out_fftpts/out_inverse:
  - Travel per beat, so they stay constant from sop through eop even with the next frame's cfg already latched.
  - When the skid is empty they hold their last value.
- in_ready is registered. It is derived from skid occupancy after the current cycle's push/pop, so no combinational in_ready←out_ready path exists.
- frame_count increments on out_valid&&out_ready&&out_eop.
- busy = (state==STREAM) || skid non-empty.
- No upstream samples are consumed in IDLE. A sample offered without cfg simply waits.

Decomposition:
- Shared package fft_pkg: DATA_W, PTS_W, MIN_PTS, MAX_PTS; a beat struct {real, imag, sop, eop, pts, inverse}; the function is_legal_pts().
- One sub-module: fft_st_skid (generic two-entry registered skid buffer over the beat struct), reused later on the FFT source side.

Test Plan:
- cfg 64/fwd, 64 samples real=i imag=-i, out_ready=1 → 64 beats from cycle 2.
  - sop only on beat 0, eop only on beat 63, fftpts=64, inverse=0, frame_count=1.
- Same frame with out_ready toggling at random 50% → identical beat sequence, no loss or duplication.
  - in_ready low within 1 cycle after the skid fills; never more than 2 beats outstanding.
- cfg 100 → cfg accepted, cfg_err=1, state stays IDLE, in_ready=0.
  - A following cfg 128 streams normally with cfg_err still 1.
- Back-to-back cfg 64/fwd then 128/inv with continuous input → no idle gap beyond 1 cycle.
  - Beats 0–63 carry fftpts=64, inverse=0; beats 64–191 carry fftpts=128, inverse=1; frame_count=2.
- Reset asserted after 30 beats of a 256-pt frame → out_valid=0 and cfg_ready=0 during reset, frame_count=0.
  - After release, cfg 64 yields a clean frame starting with sop.
- Boundary lengths 64 and 262144 accepted, 32 and 524288 rejected.
  - For 262144: eop on exactly the 262144th beat.
